// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle FETCH/DECODE/EXEC/MEM/WB control for the MIPS core.
// Shares one Avalon-style bus (with waitrequest) between instruction fetch and
// load/store, and drives the PC, IR and register-file write enables.
// Optional feature macro: MC_SEQ_BUS_TIMEOUT_EN (bounded waitrequest stall, sets bus_error).
module mc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_be,
  input  logic [31:0] store_data,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        writes_reg,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [31:0] load_data,
  output logic [31:0] pc_reset_val,
  output logic        active,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    ST_RST,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        mem_op;
  logic        mem_rd;
  logic        mem_wr;
  logic        timeout_hit;

  // Both is_load and is_store high is an illegal decode and is handled as a load.
  assign mem_op = is_load | is_store;
  assign mem_rd = is_load;
  assign mem_wr = is_store & ~is_load;

  assign pc_reset_val = RESET_VECTOR;

`ifdef MC_SEQ_BUS_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] stall_cnt;
  logic          stalled;
  logic          bus_err_q;

  assign stalled     = waitrequest & ((state == ST_FETCH) | (state == ST_MEM));
  // Fires on the TIMEOUT-th consecutive stalled cycle so HALT follows at that edge.
  assign timeout_hit = stalled & (stall_cnt == CW'(TIMEOUT - 1));
  assign bus_error   = bus_err_q;

  // Consecutive-stall counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      bus_err_q <= 1'b0;
    end else if (clk_enable) begin
      stall_cnt <= (stalled && !timeout_hit) ? stall_cnt + 1'b1 : '0;
      if (timeout_hit) bus_err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign bus_error      = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // State register; async reset returns to RST so bus strobes drop immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RST;
    else if (clk_enable) state <= state_nx;
  end

  // Capture the load/store operands in EXEC so MEM drives stable bus values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (clk_enable && state == ST_EXEC && mem_op) begin
      addr_q  <= data_addr;
      be_q    <= data_be;
      wdata_q <= store_data;
    end
  end

  // Capture the load word on the completing MEM cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) load_data <= '0;
    else if (clk_enable && state == ST_MEM && mem_rd && !waitrequest) load_data <= readdata;
  end

  // Next-state and output decode from the registered state and live inputs.
  always_comb begin
    state_nx   = state;
    address    = '0;
    read       = 1'b0;
    write      = 1'b0;
    byteenable = '0;
    writedata  = '0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    active     = (state != ST_RST) && (state != ST_HALT);

    case (state)
      ST_RST: state_nx = ST_FETCH;
      ST_FETCH: begin
        read       = 1'b1;
        address    = pc;
        byteenable = 4'hF;
        if (!waitrequest) begin
          ir_we    = 1'b1;
          state_nx = ST_DECODE;
        end
      end
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC: begin
        if (mem_op) begin
          state_nx = ST_MEM;
        end else begin
          rf_we    = writes_reg;
          pc_we    = 1'b1;
          state_nx = (next_pc == '0) ? ST_HALT : ST_FETCH;
        end
      end
      ST_MEM: begin
        address    = addr_q;
        byteenable = be_q;
        read       = mem_rd;
        write      = mem_wr;
        if (mem_wr) writedata = wdata_q;
        if (!waitrequest) begin
          if (mem_rd) begin
            state_nx = ST_WB;
          end else begin
            pc_we    = 1'b1;
            state_nx = (next_pc == '0) ? ST_HALT : ST_FETCH;
          end
        end
      end
      ST_WB: begin
        rf_we    = 1'b1;
        pc_we    = 1'b1;
        state_nx = (next_pc == '0) ? ST_HALT : ST_FETCH;
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_RST;
    endcase

    if (timeout_hit) state_nx = ST_HALT;

    if (!clk_enable) begin
      ir_we = 1'b0;
      pc_we = 1'b0;
      rf_we = 1'b0;
    end
  end

endmodule
